spi_reg_ctrl: RTL and testbench

//  Frame controller that sequences the byte-level SPI slave datapath and maps it onto a register bank.

---
 rtl/spi_reg_ctrl_if.sv | 45 ++++
 rtl/spi_reg_ctrl.sv | 174 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: SPI byte engine and register bank bus for spi_reg_ctrl.
// Ports: none; slave modport = controller side, master modport = environment side.
interface spi_reg_ctrl_if #(
    parameter int AW = 7
);
    logic          spi_cs;
    logic          spi_rx_valid;
    logic [7:0]    spi_rx_byte;
    logic [7:0]    spi_tx_byte;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [7:0]    reg_rdata;
    logic          frame_done;
    logic          frame_ovf;

    modport slave (
        input  spi_cs,
        input  spi_rx_valid,
        input  spi_rx_byte,
        input  reg_rdata,
        output spi_tx_byte,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        output frame_done,
        output frame_ovf
    );

    modport master (
        output spi_cs,
        output spi_rx_valid,
        output spi_rx_byte,
        output reg_rdata,
        input  spi_tx_byte,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        input  frame_done,
        input  frame_ovf
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI frame controller mapping {rw,addr} + burst bytes onto a register bank.
// Ports: sys_clk, sys_rst (sync, active-high), bus (spi_reg_ctrl_if.slave).
// Build option: SPI_AUTOINC_EN defined -> address advances per data byte;
// undefined -> the whole frame stays on the command address.
module spi_reg_ctrl #(
    parameter int       AW        = 7,
    parameter bit [7:0] IDLE_TX   = 8'hA5,
    parameter int       MAX_BURST = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    spi_reg_ctrl_if.slave bus
);

`ifdef SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int CW = $clog2(MAX_BURST + 2);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
    localparam logic [CW-1:0] SATC = CW'(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_WAIT_CS,
        S_IDLE,
        S_CMD,
        S_FETCH,
        S_RDATA,
        S_WDATA
    } state_t;

    state_t        r_state;
    logic [7:0]    r_tx;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;
    logic          r_we;
    logic          r_re;
    logic          r_done;
    logic          r_fovf;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_any;
    logic          r_owed;

    logic [AW-1:0] w_addr_inc;
    logic [AW-1:0] w_cmd_addr;
    logic [CW-1:0] w_cnt_inc;
    logic          w_in_frame;

    assign w_addr_inc = AUTOINC ? r_addr + AW'(1) : r_addr;
    // Bit 7 is the rw flag; the address field is zero-extended or truncated to AW.
    assign w_cmd_addr = AW'({1'b0, bus.spi_rx_byte[6:0]});
    assign w_cnt_inc  = (r_cnt == SATC) ? r_cnt : r_cnt + CW'(1);
    assign w_in_frame = (r_state != S_WAIT_CS) && (r_state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_WAIT_CS;
            r_tx    <= IDLE_TX;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_done  <= 1'b0;
            r_fovf  <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_any   <= 1'b0;
            r_owed  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_done <= 1'b0;
            r_fovf <= 1'b0;
            if (w_in_frame && bus.spi_cs) begin
                // A strobe already on the bus finishes; its read data is never loaded.
                r_state <= S_IDLE;
                r_tx    <= IDLE_TX;
                r_done  <= r_any;
                r_fovf  <= r_any & r_ovf;
            end else begin
                unique case (r_state)
                    S_WAIT_CS: begin
                        if (bus.spi_cs) r_state <= S_IDLE;
                    end
                    S_IDLE: begin
                        r_tx   <= IDLE_TX;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                        r_any  <= 1'b0;
                        r_owed <= 1'b0;
                        if (!bus.spi_cs) r_state <= S_CMD;
                    end
                    S_CMD: begin
                        if (bus.spi_rx_valid) begin
                            r_any  <= 1'b1;
                            r_addr <= w_cmd_addr;
                            if (bus.spi_rx_byte[7]) begin
                                r_re    <= 1'b1;
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= S_WDATA;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (bus.spi_rx_valid) begin
                            r_any  <= 1'b1;
                            r_cnt  <= w_cnt_inc;
                            r_addr <= w_addr_inc;
                            r_owed <= 1'b1;
                            if (r_cnt >= MAXC) r_ovf <= 1'b1;
                        end
                        // reg_rdata is valid the cycle after the strobe drops.
                        if (!r_re) begin
                            r_tx    <= bus.reg_rdata;
                            r_state <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        if (bus.spi_rx_valid) begin
                            r_any  <= 1'b1;
                            r_cnt  <= w_cnt_inc;
                            r_addr <= w_addr_inc;
                            r_owed <= 1'b0;
                            if (r_cnt < MAXC) begin
                                r_re    <= 1'b1;
                                r_state <= S_FETCH;
                            end else begin
                                r_ovf <= 1'b1;
                                r_tx  <= 8'h00;
                            end
                        end else if (r_owed) begin
                            // Byte that arrived during the previous fetch.
                            r_owed <= 1'b0;
                            if (r_cnt <= MAXC) begin
                                r_re    <= 1'b1;
                                r_state <= S_FETCH;
                            end else begin
                                r_tx <= 8'h00;
                            end
                        end
                    end
                    S_WDATA: begin
                        // Advance one cycle after each write strobe.
                        if (r_we) r_addr <= w_addr_inc;
                        if (bus.spi_rx_valid) begin
                            r_any <= 1'b1;
                            r_cnt <= w_cnt_inc;
                            if (r_cnt < MAXC) begin
                                r_wdata <= bus.spi_rx_byte;
                                r_we    <= 1'b1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_WAIT_CS;
                endcase
            end
        end
    end

    assign bus.spi_tx_byte = r_tx;
    assign bus.reg_addr    = r_addr;
    assign bus.reg_wdata   = r_wdata;
    assign bus.reg_we      = r_we;
    assign bus.reg_re      = r_re;
    assign bus.frame_done  = r_done;
    assign bus.frame_ovf   = r_fovf;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed bench for spi_reg_ctrl with a register-bank model.
// Expectations follow SPI_AUTOINC_EN the same way the design does.
module tb_spi_reg_ctrl;

`ifdef SPI_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    spi_reg_ctrl_if #(.AW(7)) bus ();

    spi_reg_ctrl #(
        .AW(7),
        .IDLE_TX(8'hA5),
        .MAX_BURST(16)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [128];
    logic [6:0] wr_a [256];
    logic [7:0] wr_d [256];
    int wr_n;
    int re_n;
    int done_n;
    int both_n;
    logic last_ovf;
    logic saw_3c;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        wr_n = 0;
        re_n = 0;
        done_n = 0;
        both_n = 0;
        last_ovf = 1'b0;
        saw_3c = 1'b0;
    end

    // Register bank and bus monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (bus.reg_we) begin
            mem[bus.reg_addr] = bus.reg_wdata;
            if (wr_n < 256) begin
                wr_a[wr_n] = bus.reg_addr;
                wr_d[wr_n] = bus.reg_wdata;
            end
            wr_n++;
        end
        if (bus.reg_re) begin
            bus.reg_rdata <= mem[bus.reg_addr];
            re_n++;
        end
        if (bus.reg_we && bus.reg_re) both_n++;
        if (bus.frame_done) begin
            done_n++;
            last_ovf = bus.frame_ovf;
        end
        if (bus.spi_tx_byte == 8'h3C) saw_3c = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output logic [7:0] miso);
        miso = bus.spi_tx_byte;
        repeat (4) tick();
        bus.spi_rx_byte  = b;
        bus.spi_rx_valid = 1'b1;
        tick();
        bus.spi_rx_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        repeat (2) tick();
    endtask

    task automatic cs_high();
        bus.spi_cs = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] m0, m1, m2, m3, dm;
        int wb, rb, db;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.spi_cs = 1'b1;
        bus.spi_rx_valid = 1'b0;
        bus.spi_rx_byte = 8'h00;
        bus.reg_rdata = 8'h00;
        repeat (3) tick();
        check("rst_tx", bus.spi_tx_byte, 8'hA5);
        check("rst_addr", bus.reg_addr, 7'h00);
        check("rst_wdata", bus.reg_wdata, 8'h00);
        check("rst_strb", {bus.reg_we, bus.reg_re}, 2'b00);
        check("rst_done", {bus.frame_done, bus.frame_ovf}, 2'b00);
        rst = 1'b0;
        repeat (3) tick();

        // Write burst
        wb = wr_n;
        db = done_n;
        cs_low();
        send(8'h10, dm);
        send(8'h11, dm);
        send(8'h22, dm);
        send(8'h33, dm);
        cs_high();
        check("wr_cnt", wr_n - wb, 3);
        check("wr_a0", wr_a[wb], 7'h10);
        check("wr_d0", wr_d[wb], 8'h11);
        check("wr_a1", wr_a[wb+1], AI ? 7'h11 : 7'h10);
        check("wr_d1", wr_d[wb+1], 8'h22);
        check("wr_a2", wr_a[wb+2], AI ? 7'h12 : 7'h10);
        check("wr_d2", wr_d[wb+2], 8'h33);
        check("wr_done", done_n - db, 1);
        check("wr_ovf", last_ovf, 1'b0);

        // Read burst
        mem[7'h20] = 8'hC1;
        mem[7'h21] = 8'hC2;
        mem[7'h22] = 8'hC3;
        rb = re_n;
        db = done_n;
        cs_low();
        send(8'hA0, m0);
        send(8'h00, m1);
        send(8'h00, m2);
        send(8'h00, m3);
        cs_high();
        check("rd_m0", m0, 8'hA5);
        check("rd_m1", m1, 8'hC1);
        check("rd_m2", m2, AI ? 8'hC2 : 8'hC1);
        check("rd_m3", m3, AI ? 8'hC3 : 8'hC1);
        check("rd_re", re_n - rb, 4);
        check("rd_done", done_n - db, 1);
        check("rd_idle_tx", bus.spi_tx_byte, 8'hA5);

        // Address wrap
        wb = wr_n;
        cs_low();
        send(8'h7F, dm);
        send(8'h5A, dm);
        send(8'h6B, dm);
        cs_high();
        check("wrap_cnt", wr_n - wb, 2);
        check("wrap_a0", wr_a[wb], 7'h7F);
        check("wrap_a1", wr_a[wb+1], AI ? 7'h00 : 7'h7F);
        check("wrap_d1", wr_d[wb+1], 8'h6B);

        // Overflow
        wb = wr_n;
        db = done_n;
        cs_low();
        send(8'h40, dm);
        for (int i = 0; i < 18; i++) send(8'(i + 1), dm);
        cs_high();
        check("ovf_cnt", wr_n - wb, 16);
        check("ovf_last_a", wr_a[wb+15], AI ? 7'h4F : 7'h40);
        check("ovf_last_d", wr_d[wb+15], 8'h10);
        check("ovf_done", done_n - db, 1);
        check("ovf_flag", last_ovf, 1'b1);

        // Abort during fetch
        mem[7'h05] = 8'h3C;
        rb = re_n;
        db = done_n;
        cs_low();
        repeat (4) tick();
        bus.spi_rx_byte  = 8'h85;
        bus.spi_rx_valid = 1'b1;
        tick();
        bus.spi_rx_valid = 1'b0;
        bus.spi_cs = 1'b1;
        repeat (4) tick();
        check("abt_re", re_n - rb, 1);
        check("abt_tx", bus.spi_tx_byte, 8'hA5);
        check("abt_late", saw_3c, 1'b0);
        check("abt_done", done_n - db, 1);
        check("abt_ovf", last_ovf, 1'b0);

        // Reset mid-frame
        wb = wr_n;
        db = done_n;
        cs_low();
        send(8'h10, dm);
        send(8'h99, dm);
        check("mr_pre_wr", wr_n - wb, 1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("mr_tx", bus.spi_tx_byte, 8'hA5);
        check("mr_addr", bus.reg_addr, 7'h00);
        check("mr_wdata", bus.reg_wdata, 8'h00);
        wb = wr_n;
        send(8'h33, dm);
        send(8'h44, dm);
        check("mr_ign_wr", wr_n - wb, 0);
        check("mr_ign_re", {bus.reg_we, bus.reg_re}, 2'b00);
        cs_high();
        check("mr_no_done", done_n - db, 0);
        cs_low();
        send(8'h30, dm);
        send(8'h77, dm);
        cs_high();
        check("mr_new_wr", wr_n - wb, 1);
        check("mr_new_a", wr_a[wb], 7'h30);
        check("mr_new_d", wr_d[wb], 8'h77);
        check("mr_new_done", done_n - db, 1);

        check("we_re_excl", both_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
